btn_debounce_array: RTL
=======================

Name: btn_debounce_array

Overview:
- Parametrised N-channel successor to the two-input button debouncer.
- Per channel: synchronises an asynchronous mechanical input, debounces it with a programmable stable-time counter, and produces a clean level plus one-cycle press/release pulses.
- Sits between board pins (btn_l/r/u/d/c, future switches) and input_manager, in the game_clk domain.
- Adds a reset, input polarity selection, edge pulses and optional auto-repeat. The old block had none of these and no defined power-up state.

Parameters:
- N_CH, 5, number of independent channels (1..32).
- DB_CYCLES, 250000, consecutive stable cycles required before the level changes (≥2; 10 ms at 25 MHz).
- ACTIVE_LOW, 0, when 1 the raw inputs are inverted after synchronisation so that level 1 always means pressed.
- RPT_DELAY, 6250000, cycles held before the first auto-repeat (250 ms). Used only with the optional feature.
- RPT_PERIOD, 1250000, cycles between subsequent repeats (50 ms). Used only with the optional feature.

Ports:
- clk  in  1  game clock.
- rst  in  1  synchronous, active-high reset.
- btn_raw  in  N_CH  asynchronous raw inputs.
- btn_level  out  N_CH  debounced pressed state.
- btn_press  out  N_CH  one-cycle pulse on a debounced 0→1 transition (plus repeats when the optional feature is enabled).
- btn_release  out  N_CH  one-cycle pulse on a debounced 1→0 transition.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst). All state updates on posedge clk.
- Reset: while rst=1, all outputs are 0, synchroniser flops are 0, and all counters are 0. Reset mid-bounce discards partial counts. After reset, a channel held pressed reports level=1 only after a full debounce period, and that report is accompanied by a press pulse.
- Sync: two-flop synchroniser per bit, giving s[i]. Polarity inversion (ACTIVE_LOW) is applied to s[i], not to the raw pin.
- Debounce, per channel, with a counter cnt of width $clog2(DB_CYCLES):
  - If s[i] == btn_level[i]: cnt is cleared.
  - If s[i] != btn_level[i] and cnt < DB_CYCLES-1: cnt increments.
  - If s[i] != btn_level[i] and cnt == DB_CYCLES-1: btn_level[i] toggles and cnt clears.
  - Any single-cycle agreement restarts the count. A glitch shorter than DB_CYCLES never propagates.
- Latency: a raw step to the level change takes exactly DB_CYCLES+2 clocks. This is constant per channel.
- Pulses are registered and asserted in the same cycle btn_level changes. btn_press and btn_release are never both high on the same channel.
- Channels are fully independent. Simultaneous transitions on several channels give simultaneous pulses.
- No wrap-around: cnt saturates at DB_CYCLES-1 by design, because it clears on toggle.

Optional Feature:
- Macro: BTN_AUTOREPEAT_EN.
- Defined: each channel gets a held-time counter (width $clog2(max(RPT_DELAY,RPT_PERIOD))) that runs while btn_level=1.
  - The counter clears on the initial press.
  - On reaching RPT_DELAY-1 it emits btn_press for one cycle and reloads to count RPT_PERIOD.
  - Thereafter it emits btn_press every RPT_PERIOD cycles.
  - Release or rst clears it immediately, and no further repeats occur.
  - btn_release is unaffected.
- Undefined: btn_press fires only on the debounced 0→1 edge. The held counters and the RPT_* parameters are unused and generate no logic.

Decomposition:
- Shared package (GLOBAL) holds:
  - the board button index constants BTN_L=0, BTN_R=1, BTN_U=2, BTN_D=3, BTN_C=4;
  - the default DB_CYCLES/RPT_* values derived from the 25 MHz game_clk.
- One natural sub-module: btn_debounce_ch, the single-channel sync + counter + pulse logic (including the repeat counter under the macro). The top instantiates it with a generate loop over N_CH.

Test Plan (bench with DB_CYCLES=8, RPT_DELAY=20, RPT_PERIOD=5, N_CH=5):
1. Clean step on ch0 at cycle 0 → btn_level[0]=1 and btn_press[0]=1 at cycle 10 only. Clean drop → btn_release[0] pulse 10 cycles later.
2. Bounce on ch1: 1 for 7 cycles, 0 for 1 cycle, then 1 steady → level rises 10 cycles after the final 0→1; no pulse before that.
3. ACTIVE_LOW=1, inputs idle at 1 → level stays 0. Drive ch2 to 0 → level=1 after 10 cycles.
4. Assert rst for 1 cycle midway through a count (cnt=5) on ch3 → outputs 0 and the count restarts: level rises 10 cycles after rst deassert, not earlier.
5. Simultaneous steps on all 5 channels → btn_press=5'b11111 in exactly one cycle.
6. With BTN_AUTOREPEAT_EN, hold ch4 → btn_press at cycles 10, 30, 35, 40… Release → pulses stop and btn_release fires. Without the macro → btn_press only at cycle 10.

Source files
------------

// File: rtl/btn_debounce_array_pkg.sv
// btn_debounce_array_pkg: board button indices and game_clk-derived debounce/repeat timing defaults.
package btn_debounce_array_pkg;
  localparam int GAME_CLK_HZ = 25_000_000;
  localparam int DB_CYCLES_DEF = GAME_CLK_HZ / 100;
  localparam int RPT_DELAY_DEF = GAME_CLK_HZ / 4;
  localparam int RPT_PERIOD_DEF = GAME_CLK_HZ / 20;
  typedef enum logic [2:0] {
    BTN_L = 3'd0,
    BTN_R = 3'd1,
    BTN_U = 3'd2,
    BTN_D = 3'd3,
    BTN_C = 3'd4
  } btn_idx_e;
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/btn_debounce_ch.sv
// btn_debounce_ch: one channel of sync + stable-time debounce + press/release pulses.
// Auto-repeat on btn_press is built only when BTN_AUTOREPEAT_EN is defined.
module btn_debounce_ch
  import btn_debounce_array_pkg::*;
#(
  parameter int DB_CYCLES  = DB_CYCLES_DEF,
  parameter int ACTIVE_LOW = 0,
  parameter int RPT_DELAY  = RPT_DELAY_DEF,
  parameter int RPT_PERIOD = RPT_PERIOD_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_press,
  output logic o_release
);
  localparam int CW = $clog2(DB_CYCLES);
  localparam logic POL = (ACTIVE_LOW != 0);
  logic [1:0] r_sync;
  logic [CW-1:0] r_cnt;
  logic r_level, r_press, r_release;
  logic w_s, w_diff, w_toggle, w_rpt;
  assign w_s = r_sync[1] ^ POL;
  assign w_diff = w_s != r_level;
  assign w_toggle = w_diff && r_cnt == CW'(DB_CYCLES - 1);
`ifdef BTN_AUTOREPEAT_EN
  localparam int HW = $clog2(max_int(RPT_DELAY, RPT_PERIOD));
  logic [HW-1:0] r_hcnt;
  logic r_rep;
  // r_rep selects the period target once the initial delay has elapsed
  assign w_rpt = r_level && !w_toggle
              && r_hcnt == (r_rep ? HW'(RPT_PERIOD - 1) : HW'(RPT_DELAY - 1));
  always_ff @(posedge clk) begin
    if (rst || !r_level || w_toggle) begin
      r_hcnt <= '0;
      r_rep  <= 1'b0;
    end else begin
      r_hcnt <= w_rpt ? '0 : r_hcnt + 1'b1;
      r_rep  <= r_rep | w_rpt;
    end
  end
`else
  // Repeat timing is not built here; this folds to a constant 0.
  assign w_rpt = (RPT_DELAY < 0) && (RPT_PERIOD < 0);
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync    <= '0;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], i_raw};
      r_cnt     <= (w_diff && !w_toggle) ? r_cnt + 1'b1 : '0;
      r_level   <= r_level ^ w_toggle;
      r_press   <= (w_toggle && !r_level) || w_rpt;
      r_release <= w_toggle && r_level;
    end
  end
  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;
endmodule

// File: rtl/btn_debounce_array.sv
// btn_debounce_array: N_CH independent button debouncers with level and press/release pulses.
// Define BTN_AUTOREPEAT_EN to add held-button auto-repeat on btn_press.
module btn_debounce_array
  import btn_debounce_array_pkg::*;
#(
  parameter int N_CH       = 5,
  parameter int DB_CYCLES  = DB_CYCLES_DEF,
  parameter int ACTIVE_LOW = 0,
  parameter int RPT_DELAY  = RPT_DELAY_DEF,
  parameter int RPT_PERIOD = RPT_PERIOD_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_raw,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_press,
  output logic [N_CH-1:0] btn_release
);
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    btn_debounce_ch #(
      .DB_CYCLES (DB_CYCLES),
      .ACTIVE_LOW(ACTIVE_LOW),
      .RPT_DELAY (RPT_DELAY),
      .RPT_PERIOD(RPT_PERIOD)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .i_raw    (btn_raw[g]),
      .o_level  (btn_level[g]),
      .o_press  (btn_press[g]),
      .o_release(btn_release[g])
    );
  end
endmodule
